// File: rtl/weighted_rr_arbiter.sv
// Four-requester weighted round-robin arbiter with a registered one-hot grant.
// Each owner keeps the grant for up to its weight in counted beats, then ownership rotates.
module weighted_rr_arbiter #(
    parameter int WEIGHT_W       = 3,
    parameter int DEFAULT_WEIGHT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          req,
    input  logic                beat,
    input  logic                cfg_we,
    input  logic [1:0]          cfg_idx,
    input  logic [WEIGHT_W-1:0] cfg_weight,
    output logic [3:0]          grant,
    output logic [1:0]          grant_id,
    output logic                busy,
    output logic                quota_end,
    output logic                dbg_state
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    state_e              state_q;
    logic [1:0]          owner_q;
    logic [1:0]          ptr_q;
    logic [WEIGHT_W-1:0] credit_q;
    logic [WEIGHT_W-1:0] weight_q [4];
    logic [3:0]          grant_q;
    logic                busy_q;

    logic [2:0]          idle_pick;
    logic [2:0]          rel_pick;
    logic                hit_d;
    logic [1:0]          owner_d;
    logic                counted;
    logic                release_grant;

    // Returns {hit, index} of the first set request at start, start+1, ... (mod 4).
    function automatic logic [2:0] find_first(input logic [3:0] r, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = start + 2'(i);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    function automatic logic [WEIGHT_W-1:0] eff_weight(input logic [WEIGHT_W-1:0] w);
        return (w == '0) ? WEIGHT_W'(1) : w;
    endfunction

    // Starting the release search at owner+1 visits the current owner last.
    always_comb begin
        idle_pick     = find_first(req, ptr_q);
        rel_pick      = find_first(req, owner_q + 2'd1);
        hit_d         = (state_q == IDLE) ? idle_pick[2]   : rel_pick[2];
        owner_d       = (state_q == IDLE) ? idle_pick[1:0] : rel_pick[1:0];
        counted       = (state_q == GRANT) && beat && req[owner_q];
        quota_end     = counted && (credit_q == WEIGHT_W'(1));
        release_grant = (state_q == GRANT) && (!req[owner_q] || quota_end);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            ptr_q    <= '0;
            credit_q <= '0;
            grant_q  <= '0;
            busy_q   <= 1'b0;
            for (int i = 0; i < 4; i++) weight_q[i] <= WEIGHT_W'(DEFAULT_WEIGHT);
        end else begin
            // Credit loads below read weight_q before this write lands.
            if (cfg_we) weight_q[cfg_idx] <= cfg_weight;
            case (state_q)
                IDLE: begin
                    if (hit_d) begin
                        state_q  <= GRANT;
                        owner_q  <= owner_d;
                        grant_q  <= 4'b0001 << owner_d;
                        busy_q   <= 1'b1;
                        credit_q <= eff_weight(weight_q[owner_d]);
                    end
                end
                GRANT: begin
                    if (release_grant) begin
                        ptr_q <= owner_q + 2'd1;
                        if (hit_d) begin
                            owner_q  <= owner_d;
                            grant_q  <= 4'b0001 << owner_d;
                            credit_q <= eff_weight(weight_q[owner_d]);
                        end else begin
                            state_q  <= IDLE;
                            owner_q  <= '0;
                            grant_q  <= '0;
                            busy_q   <= 1'b0;
                            credit_q <= '0;
                        end
                    end else if (counted) begin
                        credit_q <= credit_q - WEIGHT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant     = grant_q;
    assign grant_id  = owner_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_weighted_rr_arbiter.sv
// Directed bench for weighted_rr_arbiter: each task drives one scenario and checks
// grant, grant_id, busy and quota_end against hand-computed values.
module tb_weighted_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       beat;
    logic       cfg_we;
    logic [1:0] cfg_idx;
    logic [2:0] cfg_weight;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       busy;
    logic       quota_end;
    logic       dbg_state;

    int n_checks;
    int n_fail;

    logic [1:0] exp_id [7];
    logic       exp_qe [7];

    weighted_rr_arbiter #(.WEIGHT_W(3), .DEFAULT_WEIGHT(1)) dut (
        .clk(clk), .rst(rst), .req(req), .beat(beat),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_weight(cfg_weight),
        .grant(grant), .grant_id(grant_id), .busy(busy),
        .quota_end(quota_end), .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; req = 4'b0000; beat = 1'b0; cfg_we = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic cfg_write(input logic [1:0] idx, input logic [2:0] w);
        cfg_we = 1'b1; cfg_idx = idx; cfg_weight = w;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; req = 4'b1111; beat = 1'b1; cfg_we = 1'b0;
        tick();
        tick();
        n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b want 0000", grant); end
        n_checks++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_id: got %0d want 0", grant_id); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (quota_end !== 1'b0) begin n_fail++; $display("FAIL reset_qe: got %b want 0", quota_end); end
        n_checks++; if (dbg_state !== 1'b0) begin n_fail++; $display("FAIL reset_state: got %b want 0", dbg_state); end
        rst = 1'b0; req = 4'b0000; beat = 1'b1;
        tick();
        tick();
        n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL idle_beat_grant: got %b want 0000", grant); end
        n_checks++; if (quota_end !== 1'b0) begin n_fail++; $display("FAIL idle_beat_qe: got %b want 0", quota_end); end
    endtask

    task automatic test_single;
        req = 4'b0001; beat = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL single_grant[%0d]: got %b want 0001", i, grant); end
            n_checks++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL single_id[%0d]: got %0d want 0", i, grant_id); end
            n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy[%0d]: got %b want 1", i, busy); end
            n_checks++; if (quota_end !== 1'b1) begin n_fail++; $display("FAIL single_qe[%0d]: got %b want 1", i, quota_end); end
        end
        req = 4'b0000; beat = 1'b0;
        tick();
        n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL single_release: got %b want 0000", grant); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_off: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back;
        do_reset();
        cfg_write(2'd0, 3'd3);
        cfg_write(2'd1, 3'd1);
        cfg_write(2'd2, 3'd2);
        cfg_write(2'd3, 3'd1);
        exp_id = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd3};
        exp_qe = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        req = 4'b1111; beat = 1'b1;
        for (int i = 0; i < 14; i++) begin
            tick();
            n_checks++; if (grant !== (4'b0001 << exp_id[i % 7])) begin n_fail++; $display("FAIL b2b_grant[%0d]: got %b want id %0d", i, grant, exp_id[i % 7]); end
            n_checks++; if (grant_id !== exp_id[i % 7]) begin n_fail++; $display("FAIL b2b_id[%0d]: got %0d want %0d", i, grant_id, exp_id[i % 7]); end
            n_checks++; if (quota_end !== exp_qe[i % 7]) begin n_fail++; $display("FAIL b2b_qe[%0d]: got %b want %b", i, quota_end, exp_qe[i % 7]); end
        end
        req = 4'b0000; beat = 1'b0;
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got busy %b want 0", busy); end
    endtask

    task automatic test_withdraw;
        do_reset();
        cfg_write(2'd2, 3'd4);
        cfg_write(2'd0, 3'd2);
        req = 4'b0100; beat = 1'b0;
        tick();
        n_checks++; if (grant !== 4'b0100) begin n_fail++; $display("FAIL wd_first: got %b want 0100", grant); end
        req = 4'b0101; beat = 1'b1;
        #1;
        n_checks++; if (quota_end !== 1'b0) begin n_fail++; $display("FAIL wd_beat_qe: got %b want 0", quota_end); end
        tick();
        n_checks++; if (grant !== 4'b0100) begin n_fail++; $display("FAIL wd_hold: got %b want 0100", grant); end
        req = 4'b0001; beat = 1'b0;
        #1;
        n_checks++; if (quota_end !== 1'b0) begin n_fail++; $display("FAIL wd_drop_qe: got %b want 0", quota_end); end
        tick();
        n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL wd_next: got %b want 0001", grant); end
        n_checks++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL wd_next_id: got %0d want 0", grant_id); end
        beat = 1'b1;
        #1;
        n_checks++; if (quota_end !== 1'b0) begin n_fail++; $display("FAIL wd_reload1: got %b want 0", quota_end); end
        tick();
        n_checks++; if (quota_end !== 1'b1) begin n_fail++; $display("FAIL wd_reload2: got %b want 1", quota_end); end
        req = 4'b0000; beat = 1'b0;
        tick();
        req = 4'b0100;
        tick();
        n_checks++; if (grant !== 4'b0100) begin n_fail++; $display("FAIL wd_ptr1: got %b want 0100", grant); end
        req = 4'b0000;
        tick();
        n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL wd_to_idle: got %b want 0000", grant); end
        req = 4'b1001;
        tick();
        n_checks++; if (grant !== 4'b1000) begin n_fail++; $display("FAIL wd_ptr3: got %b want 1000", grant); end
        n_checks++; if (grant_id !== 2'd3) begin n_fail++; $display("FAIL wd_ptr3_id: got %0d want 3", grant_id); end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_cfg_during_grant;
        logic exp_cfg_qe [8];
        exp_cfg_qe = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        do_reset();
        cfg_write(2'd1, 3'd3);
        req = 4'b0010; beat = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            cfg_we = 1'b0;
            n_checks++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL cfg_grant[%0d]: got %b want 0010", c, grant); end
            n_checks++; if (quota_end !== exp_cfg_qe[c]) begin n_fail++; $display("FAIL cfg_qe[%0d]: got %b want %b", c, quota_end, exp_cfg_qe[c]); end
            if (c == 0) begin cfg_we = 1'b1; cfg_idx = 2'd1; cfg_weight = 3'd0; end
            if (c == 3) begin cfg_we = 1'b1; cfg_idx = 2'd1; cfg_weight = 3'd3; end
        end
        req = 4'b0000; beat = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid;
        do_reset();
        cfg_write(2'd1, 3'd3);
        req = 4'b0010; beat = 1'b0;
        tick();
        n_checks++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL rm_pre: got %b want 0010", grant); end
        req = 4'b1111;
        tick();
        rst = 1'b1;
        tick();
        n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL rm_grant: got %b want 0000", grant); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy: got %b want 0", busy); end
        n_checks++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL rm_id: got %0d want 0", grant_id); end
        rst = 1'b0; beat = 1'b1;
        tick();
        n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL rm_after: got %b want 0001", grant); end
        n_checks++; if (quota_end !== 1'b1) begin n_fail++; $display("FAIL rm_after_qe: got %b want 1", quota_end); end
        tick();
        n_checks++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL rm_next: got %b want 0010", grant); end
        n_checks++; if (quota_end !== 1'b1) begin n_fail++; $display("FAIL rm_next_qe: got %b want 1", quota_end); end
        tick();
        n_checks++; if (grant !== 4'b0100) begin n_fail++; $display("FAIL rm_third: got %b want 0100", grant); end
        req = 4'b0000; beat = 1'b0;
        tick();
    endtask

    task automatic test_stall;
        do_reset();
        cfg_write(2'd3, 3'd2);
        req = 4'b1000; beat = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (grant !== 4'b1000) begin n_fail++; $display("FAIL stall_grant[%0d]: got %b want 1000", i, grant); end
            n_checks++; if (quota_end !== 1'b0) begin n_fail++; $display("FAIL stall_qe[%0d]: got %b want 0", i, quota_end); end
            tick();
        end
        beat = 1'b1;
        #1;
        n_checks++; if (quota_end !== 1'b0) begin n_fail++; $display("FAIL stall_beat1: got %b want 0", quota_end); end
        tick();
        n_checks++; if (grant !== 4'b1000) begin n_fail++; $display("FAIL stall_beat2_grant: got %b want 1000", grant); end
        n_checks++; if (quota_end !== 1'b1) begin n_fail++; $display("FAIL stall_beat2_qe: got %b want 1", quota_end); end
        req = 4'b0000; beat = 1'b0;
        tick();
        n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL stall_idle: got %b want 0000", grant); end
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        rst = 1'b1; req = 4'b0000; beat = 1'b0;
        cfg_we = 1'b0; cfg_idx = 2'd0; cfg_weight = 3'd0;
        test_reset();
        test_single();
        test_back_to_back();
        test_withdraw();
        test_cfg_during_grant();
        test_reset_mid();
        test_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
